// File: rtl/i2c_byte_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_byte_ctrl
//   Byte-level command sequencer sitting directly above the I2C bit PHY.
//   Takes one byte command (optional START, WRITE or READ, ACK phase, optional
//   STOP), breaks it into single-bit PHY commands, shifts data MSB-first and
//   returns the received byte plus the slave ACK bit.
//
// Optional feature (compile-time macro): I2C_BYTE_CMD_TIMEOUT_EN
//   Adds a bit-ack watchdog (to_limit_i / timeout_o ports, TO_W parameter).
//   A stalled PHY command is aborted like an arbitration loss.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   ena_i           enable; no new command accepted while low
//   start_i/stop_i  generate (repeated) START before / STOP after the byte
//   read_i/write_i  byte direction (write wins when both are set)
//   ack_in_i        ACK bit sent after a read (0 = ACK, 1 = NACK)
//   din_i           byte to write
//   cmd_ack_o       one-cycle pulse when the byte command completes
//   ack_out_o       ACK bit sampled from the slave after a write
//   dout_o          received byte
//   i2c_al_o        one-cycle pulse on arbitration loss
//   busy_o          high while a command is in progress
//   to_limit_i      watchdog limit in clk cycles, 0 disables (macro only)
//   timeout_o       one-cycle pulse on watchdog expiry (macro only)
//   bit_cmd_o       PHY command: 0 NOP, 1 START, 2 STOP, 4 WRITE, 8 READ
//   bit_cmd_ack_i   PHY completion pulse
//   bit_al_i        PHY arbitration-lost indication
//   bit_din_o       bit transmitted with WRITE
//   bit_dout_i      bit received, valid on bit_cmd_ack_i of READ
// -----------------------------------------------------------------------------
module i2c_byte_ctrl #(
  parameter int CMD_W = 4
`ifdef I2C_BYTE_CMD_TIMEOUT_EN
  ,
  parameter int TO_W  = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             read_i,
  input  logic             write_i,
  input  logic             ack_in_i,
  input  logic [7:0]       din_i,
  output logic             cmd_ack_o,
  output logic             ack_out_o,
  output logic [7:0]       dout_o,
  output logic             i2c_al_o,
  output logic             busy_o,
`ifdef I2C_BYTE_CMD_TIMEOUT_EN
  input  logic [TO_W-1:0]  to_limit_i,
  output logic             timeout_o,
`endif
  output logic [CMD_W-1:0] bit_cmd_o,
  input  logic             bit_cmd_ack_i,
  input  logic             bit_al_i,
  output logic             bit_din_o,
  input  logic             bit_dout_i
);

  localparam logic [CMD_W-1:0] CMD_NOP   = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_START = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_STOP  = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_WRITE = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_READ  = CMD_W'(8);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_BIT, ST_ACK, ST_STOP} state_e;

  state_e           state_q, state_d;
  logic             stop_q, stop_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic             ack_in_q, ack_in_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CMD_W-1:0] bit_cmd_q, bit_cmd_d;
  logic             bit_din_q, bit_din_d;
  logic             cmd_ack_q, cmd_ack_d;
  logic             ack_out_q, ack_out_d;
  logic [7:0]       dout_q, dout_d;
  logic             al_q, al_d;
  logic             to_hit;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    stop_d    = stop_q;
    read_d    = read_q;
    write_d   = write_q;
    ack_in_d  = ack_in_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    bit_cmd_d = bit_cmd_q;
    bit_din_d = bit_din_q;
    cmd_ack_d = 1'b0;
    ack_out_d = ack_out_q;
    dout_d    = dout_q;
    al_d      = 1'b0;

    if (state_q == ST_IDLE) begin
      if (ena_i && (start_i || stop_i || read_i || write_i)) begin
        stop_d   = stop_i;
        write_d  = write_i;
        read_d   = read_i & ~write_i;
        ack_in_d = ack_in_i;
        sr_d     = din_i;
        cnt_d    = 3'd7;
        if (start_i) begin
          state_d   = ST_START;
          bit_cmd_d = CMD_START;
        end else if (read_i || write_i) begin
          state_d   = ST_BIT;
          bit_cmd_d = write_i ? CMD_WRITE : CMD_READ;
          bit_din_d = din_i[7];
        end else begin
          state_d   = ST_STOP;
          bit_cmd_d = CMD_STOP;
        end
      end
    end else if (bit_al_i || to_hit) begin
      // Abort: arbitration loss outranks a same-cycle ack or watchdog hit.
      state_d   = ST_IDLE;
      bit_cmd_d = CMD_NOP;
      bit_din_d = 1'b0;
      al_d      = bit_al_i;
    end else if (bit_cmd_ack_i) begin
      // The next PHY command is loaded on the ack so there is no NOP gap.
      unique case (state_q)
        ST_START: begin
          if (read_q || write_q) begin
            state_d   = ST_BIT;
            bit_cmd_d = write_q ? CMD_WRITE : CMD_READ;
            bit_din_d = sr_q[7];
          end else if (stop_q) begin
            state_d   = ST_STOP;
            bit_cmd_d = CMD_STOP;
          end else begin
            state_d   = ST_IDLE;
            bit_cmd_d = CMD_NOP;
            cmd_ack_d = 1'b1;
          end
        end
        ST_BIT: begin
          sr_d  = {sr_q[6:0], bit_dout_i};
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            // ACK phase runs opposite to the data direction.
            state_d   = ST_ACK;
            bit_cmd_d = write_q ? CMD_READ : CMD_WRITE;
            bit_din_d = write_q ? 1'b1 : ack_in_q;
          end else begin
            bit_din_d = sr_q[6];
          end
        end
        ST_ACK: begin
          if (write_q) ack_out_d = bit_dout_i;
          else         dout_d    = sr_q;
          if (stop_q) begin
            state_d   = ST_STOP;
            bit_cmd_d = CMD_STOP;
          end else begin
            state_d   = ST_IDLE;
            bit_cmd_d = CMD_NOP;
            cmd_ack_d = 1'b1;
          end
        end
        ST_STOP: begin
          state_d   = ST_IDLE;
          bit_cmd_d = CMD_NOP;
          cmd_ack_d = 1'b1;
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cmd_d = CMD_NOP;
        end
      endcase
    end
  end

`ifdef I2C_BYTE_CMD_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_inc;
  logic            timeout_q;

  assign to_cnt_inc = to_cnt_q + TO_W'(1);
  // Fires on the cycle the counter would reach the limit, so the pulse lands
  // exactly to_limit cycles after the stalled command appeared.
  assign to_hit = (to_limit_i != '0) && (bit_cmd_q != CMD_NOP) &&
                  !bit_cmd_ack_i && (to_cnt_inc == to_limit_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_hit && !bit_al_i;
      if (bit_cmd_ack_i || (bit_cmd_d != bit_cmd_q)) to_cnt_q <= '0;
      else if (bit_cmd_q != CMD_NOP)                 to_cnt_q <= to_cnt_inc;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stop_q    <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      ack_in_q  <= 1'b0;
      sr_q      <= 8'h00;
      cnt_q     <= 3'd0;
      bit_cmd_q <= CMD_NOP;
      bit_din_q <= 1'b0;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      dout_q    <= 8'h00;
      al_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      stop_q    <= stop_d;
      read_q    <= read_d;
      write_q   <= write_d;
      ack_in_q  <= ack_in_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      bit_cmd_q <= bit_cmd_d;
      bit_din_q <= bit_din_d;
      cmd_ack_q <= cmd_ack_d;
      ack_out_q <= ack_out_d;
      dout_q    <= dout_d;
      al_q      <= al_d;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign cmd_ack_o = cmd_ack_q;
  assign ack_out_o = ack_out_q;
  assign dout_o    = dout_q;
  assign i2c_al_o  = al_q;
  assign bit_cmd_o = bit_cmd_q;
  assign bit_din_o = bit_din_q;

endmodule
